// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/PC sequencer for the FD, DE, EM and MW pipeline registers of one core.
// Define HAZARD_PERF_EN to add saturating load-use, flush-event and dcache-wait counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             em_dmemREN,
    input  logic             em_dmemWEN,
    input  logic             de_memread,
    input  logic [4:0]       de_rt,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rt,
    input  logic             ex_redirect,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             dec_jump,
    input  logic             mw_halt,
    output logic             fd_stall,
    output logic             de_stall,
    output logic             em_stall,
    output logic             mw_stall,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [PC_W-1:0]  pc_target,
    output logic             halt_out
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] dwait_cnt
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;
    logic            pend_redir_q, pend_redir_d;
    logic            freeze_s;
    logic            load_use_s;

    assign freeze_s   = (em_dmemREN | em_dmemWEN) & ~dhit;
    assign load_use_s = de_memread & (de_rt != 5'd0) &
                        ((de_rt == fd_rs) | (fd_uses_rt & (de_rt == fd_rt)));
    assign halt_out   = (state_q == ST_HALT);

    // Hazard resolution: control outputs and next state from current state and hazards.
    always_comb begin
        fd_stall      = 1'b0;
        de_stall      = 1'b0;
        em_stall      = 1'b0;
        mw_stall      = 1'b0;
        fd_flush      = 1'b0;
        de_flush      = 1'b0;
        em_flush      = 1'b0;
        pc_en         = 1'b0;
        pc_redirect   = 1'b0;
        pc_target     = pend_target_q;
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pend_redir_d  = pend_redir_q;
        if (freeze_s || (state_q == ST_HALT)) begin
            // A dcache miss freezes everything in place; a halted core stays frozen.
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
            mw_stall = 1'b1;
        end else if (mw_halt) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            state_d  = ST_HALT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_redirect) begin
                        fd_flush    = 1'b1;
                        de_flush    = 1'b1;
                        pc_redirect = 1'b1;
                        pc_target   = ex_target;
                        pc_en       = ihit;
                        if (!ihit) begin
                            pend_target_d = ex_target;
                            pend_redir_d  = 1'b1;
                            state_d       = ST_PEND;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (dec_jump) begin
                        fd_flush = 1'b1;
                        pc_en    = ihit;
                        if (!ihit) begin
                            pend_redir_d = 1'b0;
                            state_d      = ST_PEND;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (load_use_s) begin
                        fd_stall = 1'b1;
                        de_flush = 1'b1;
                    end else if (!ihit) begin
                        de_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                ST_PEND: begin
                    // Keep squashing FD until fetch returns the wrong-path instruction.
                    fd_flush    = 1'b1;
                    de_flush    = 1'b1;
                    pc_en       = ihit;
                    pc_redirect = pend_redir_q;
                    if (ex_redirect) begin
                        pc_redirect   = 1'b1;
                        pc_target     = ex_target;
                        pend_target_d = ex_target;
                        pend_redir_d  = 1'b1;
                    end else begin
                        pend_redir_d  = pend_redir_q;
                    end
                    if (ihit) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and pending-redirect registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_RUN;
            pend_target_q <= {PC_W{1'b0}};
            pend_redir_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            pend_redir_q  <= pend_redir_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             lu_evt_s;
    logic             flush_evt_s;
    logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q, dwait_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Flush events count only on entry from RUN, never per pending cycle.
    assign lu_evt_s    = ~freeze_s & (state_q == ST_RUN) & ~mw_halt & ~ex_redirect &
                         ~dec_jump & load_use_s;
    assign flush_evt_s = ~freeze_s & (state_q == ST_RUN) & ~mw_halt & (ex_redirect | dec_jump);

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lu_cnt_q    <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
            dwait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            lu_cnt_q    <= sat_inc(lu_cnt_q, lu_evt_s);
            flush_cnt_q <= sat_inc(flush_cnt_q, flush_evt_s);
            dwait_cnt_q <= sat_inc(dwait_cnt_q, freeze_s);
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign dwait_cnt    = dwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a behavioural hazard model checked every cycle.
module tb_pipeline_hazard_ctrl;
    localparam int PW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Expected output vector order:
    // {fd_stall,de_stall,em_stall,mw_stall, fd_flush,de_flush,em_flush, pc_en, pc_redirect, halt_out}
    localparam logic [9:0] V_RUN   = 10'b0000_000_1_0_0;
    localparam logic [9:0] V_WAIT  = 10'b0000_010_0_0_0;
    localparam logic [9:0] V_LU    = 10'b1000_010_0_0_0;
    localparam logic [9:0] V_FRZ   = 10'b1111_000_0_0_0;
    localparam logic [9:0] V_HALT  = 10'b0000_111_0_0_0;
    localparam logic [9:0] V_HALTD = 10'b1111_000_0_0_1;

    localparam int M_RUN = 0, M_PEND = 1, M_HALT = 2;
    localparam int A_FREEZE = 0, A_HALTED = 1, A_HALT = 2, A_PEND = 3, A_REDIR = 4,
                   A_JUMP = 5, A_LU = 6, A_WAIT = 7, A_RUN = 8;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    logic ihit, dhit, em_dmemREN, em_dmemWEN, de_memread, fd_uses_rt;
    logic ex_redirect, dec_jump, mw_halt;
    logic [4:0] de_rt, fd_rs, fd_rt;
    logic [PW-1:0] ex_target, pc_target;
    logic fd_stall, de_stall, em_stall, mw_stall, fd_flush, de_flush, em_flush;
    logic pc_en, pc_redirect, halt_out;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] lu_stall_cnt, flush_cnt, dwait_cnt;
`endif
    logic [9:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    int            m_mode;
    logic [PW-1:0] m_pend;
    logic          m_redir;
    int            m_lu, m_fl, m_dw;

    assign outs = {fd_stall, de_stall, em_stall, mw_stall, fd_flush, de_flush, em_flush,
                   pc_en, pc_redirect, halt_out};

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(CW), .PC_W(PW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .em_dmemREN(em_dmemREN), .em_dmemWEN(em_dmemWEN),
        .de_memread(de_memread), .de_rt(de_rt), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .dec_jump(dec_jump), .mw_halt(mw_halt),
        .fd_stall(fd_stall), .de_stall(de_stall), .em_stall(em_stall), .mw_stall(mw_stall),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .halt_out(halt_out)
`ifdef HAZARD_PERF_EN
        , .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Which rule governs this cycle, in priority order.
    function automatic int pick_action();
        if ((em_dmemREN || em_dmemWEN) && !dhit) return A_FREEZE;
        if (m_mode == M_HALT) return A_HALTED;
        if (mw_halt) return A_HALT;
        if (m_mode == M_PEND) return A_PEND;
        if (ex_redirect) return A_REDIR;
        if (dec_jump) return A_JUMP;
        if (de_memread && de_rt != 5'd0 &&
            (de_rt == fd_rs || (fd_uses_rt && de_rt == fd_rt))) return A_LU;
        if (!ihit) return A_WAIT;
        return A_RUN;
    endfunction

    function automatic logic [9:0] exp_outs(input int a);
        case (a)
            A_FREEZE: return {4'b1111, 3'b000, 1'b0, 1'b0, (m_mode == M_HALT)};
            A_HALTED: return V_HALTD;
            A_HALT:   return V_HALT;
            A_PEND:   return {4'b0000, 3'b110, ihit, (m_redir || ex_redirect), 1'b0};
            A_REDIR:  return {4'b0000, 3'b110, ihit, 1'b1, 1'b0};
            A_JUMP:   return {4'b0000, 3'b100, ihit, 1'b0, 1'b0};
            A_LU:     return V_LU;
            A_WAIT:   return V_WAIT;
            default:  return V_RUN;
        endcase
    endfunction

    function automatic logic [PW-1:0] exp_target();
        if (ex_redirect) return ex_target;
        return m_pend;
    endfunction

    function automatic int capped(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Model state update on each clock edge.
    always @(posedge CLK) begin
        if (!nRST) begin
            m_mode  <= M_RUN;
            m_pend  <= '0;
            m_redir <= 1'b0;
            m_lu    <= 0;
            m_fl    <= 0;
            m_dw    <= 0;
        end else begin
            case (pick_action())
                A_FREEZE: m_dw <= m_dw + 1;
                A_HALT:   m_mode <= M_HALT;
                A_REDIR: begin
                    m_fl <= m_fl + 1;
                    if (!ihit) begin
                        m_mode  <= M_PEND;
                        m_pend  <= ex_target;
                        m_redir <= 1'b1;
                    end
                end
                A_JUMP: begin
                    m_fl <= m_fl + 1;
                    if (!ihit) begin
                        m_mode  <= M_PEND;
                        m_redir <= 1'b0;
                    end
                end
                A_LU: m_lu <= m_lu + 1;
                A_PEND: begin
                    if (ex_redirect) begin
                        m_pend  <= ex_target;
                        m_redir <= 1'b1;
                    end
                    if (ihit) m_mode <= M_RUN;
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (nRST) begin
            chk("model_outs", outs, exp_outs(pick_action()));
            if ((exp_outs(pick_action()) & 10'b00000_00010) != 10'd0)
                chk("model_target", pc_target, exp_target());
`ifdef HAZARD_PERF_EN
            chk("model_lu_cnt", lu_stall_cnt, capped(m_lu));
            chk("model_flush_cnt", flush_cnt, capped(m_fl));
            chk("model_dwait_cnt", dwait_cnt, capped(m_dw));
`endif
        end
    end

    task automatic clr();
        ihit = 1'b0; dhit = 1'b0; em_dmemREN = 1'b0; em_dmemWEN = 1'b0;
        de_memread = 1'b0; fd_uses_rt = 1'b0; ex_redirect = 1'b0; dec_jump = 1'b0;
        mw_halt = 1'b0; de_rt = 5'd0; fd_rs = 5'd0; fd_rt = 5'd0; ex_target = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc_chk(input string nm, input logic [9:0] e);
        @(negedge CLK);
        chk(nm, outs, e);
        tick();
    endtask

    task automatic cyc_chk_t(input string nm, input logic [9:0] e, input logic [PW-1:0] t);
        @(negedge CLK);
        chk(nm, outs, e);
        chk({nm, "_target"}, pc_target, t);
        tick();
    endtask

    task automatic reset_pulse();
        clr();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    logic [4:0] t_de  [4] = '{5'd5, 5'd0, 5'd7, 5'd7};
    logic [4:0] t_rs  [4] = '{5'd5, 5'd0, 5'd3, 5'd3};
    logic [4:0] t_rt  [4] = '{5'd0, 5'd0, 5'd7, 5'd7};
    logic       t_use [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       t_stl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        clr();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        chk("reset_outs", outs, V_WAIT);
        chk("reset_target", pc_target, 32'h0);
        tick();

        ihit = 1'b1;
        cyc_chk("normal", V_RUN);

        // Load-use table: rs match, r0 load, rt match, rt not read.
        for (int i = 0; i < 4; i++) begin
            de_memread = 1'b1; de_rt = t_de[i]; fd_rs = t_rs[i]; fd_rt = t_rt[i];
            fd_uses_rt = t_use[i];
            cyc_chk($sformatf("loaduse_%0d", i), t_stl[i] ? V_LU : V_RUN);
            clr(); ihit = 1'b1;
            cyc_chk($sformatf("loaduse_after_%0d", i), V_RUN);
        end

        // Redirect while fetch is busy.
        clr(); ex_redirect = 1'b1; ex_target = 32'h40;
        for (int i = 0; i < 3; i++) cyc_chk_t("redir_wait", 10'b0000_110_0_1_0, 32'h40);
        ex_redirect = 1'b0; ihit = 1'b1;
        cyc_chk_t("redir_release", 10'b0000_110_1_1_0, 32'h40);
        cyc_chk("redir_back_run", V_RUN);

        // Dcache miss with a redirect waiting behind it.
        em_dmemREN = 1'b1; ex_redirect = 1'b1; ex_target = 32'h80;
        for (int i = 0; i < 4; i++) cyc_chk("miss_freeze", V_FRZ);
        dhit = 1'b1;
        cyc_chk_t("miss_resume_redir", 10'b0000_110_1_1_0, 32'h80);

        // Redirect, load-use and jump together: only the redirect acts.
        clr(); ihit = 1'b1; ex_redirect = 1'b1; ex_target = 32'h100; dec_jump = 1'b1;
        de_memread = 1'b1; de_rt = 5'd5; fd_rs = 5'd5;
        cyc_chk_t("simul", 10'b0000_110_1_1_0, 32'h100);

        // Jump while fetch waits: pending flush with no PC redirect.
        clr(); dec_jump = 1'b1;
        cyc_chk("jump_wait", 10'b0000_100_0_0_0);
        dec_jump = 1'b0;
        cyc_chk("jump_pend", 10'b0000_110_0_0_0);
        ihit = 1'b1;
        cyc_chk("jump_release", 10'b0000_110_1_0_0);
        cyc_chk("jump_back_run", V_RUN);

        // Latest redirect wins while pending.
        clr(); ex_redirect = 1'b1; ex_target = 32'h200;
        cyc_chk_t("latest_a", 10'b0000_110_0_1_0, 32'h200);
        ex_target = 32'h300;
        cyc_chk_t("latest_b", 10'b0000_110_0_1_0, 32'h300);
        ex_redirect = 1'b0;
        cyc_chk_t("latest_hold", 10'b0000_110_0_1_0, 32'h300);

        // Reset while pending returns straight to RUN.
        clr(); nRST = 1'b0;
        #1 chk("reset_mid_pend", outs, V_WAIT);
        tick();
        #1 nRST = 1'b1;
        ihit = 1'b1;
        cyc_chk("after_reset_run", V_RUN);

        // Halt is sticky until reset.
        mw_halt = 1'b1;
        cyc_chk("halt_enter", V_HALT);
        mw_halt = 1'b0; ex_redirect = 1'b1; ex_target = 32'h500;
        for (int i = 0; i < 3; i++) cyc_chk("halted", V_HALTD);
        clr(); nRST = 1'b0;
        #1 chk("halt_cleared", halt_out, 1'b0);
        tick();
        #1 nRST = 1'b1;

        // Counter scenario: two load-use stalls, one pending redirect, five miss cycles.
        for (int i = 0; i < 2; i++) begin
            clr(); ihit = 1'b1; de_memread = 1'b1; de_rt = 5'd9; fd_rs = 5'd9;
            cyc_chk("perf_lu", V_LU);
            clr(); ihit = 1'b1;
            cyc_chk("perf_lu_after", V_RUN);
        end
        clr(); ex_redirect = 1'b1; ex_target = 32'h44;
        repeat (3) tick();
        ex_redirect = 1'b0; ihit = 1'b1;
        tick();
        em_dmemWEN = 1'b1;
        for (int i = 0; i < 5; i++) cyc_chk("perf_miss", V_FRZ);
        clr(); ihit = 1'b1;
        @(negedge CLK);
`ifdef HAZARD_PERF_EN
        chk("perf_lu_cnt", lu_stall_cnt, 4'd2);
        chk("perf_flush_cnt", flush_cnt, 4'd1);
        chk("perf_dwait_cnt", dwait_cnt, 4'd5);
`endif
        tick();
        em_dmemREN = 1'b1;
        repeat (12) tick();
        clr(); ihit = 1'b1;
        @(negedge CLK);
`ifdef HAZARD_PERF_EN
        chk("perf_dwait_sat", dwait_cnt, 4'd15);
`endif
        chk("perf_end_run", outs, V_RUN);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
